// File: rtl/rat_ctrl_pkg.sv
// Shared constants for the flag / interrupt control slice.
// Build option: RAT_INT_SYNC_EN selects a 2-flop INTR synchronizer.
// When it is undefined, INTR is registered once.
package rat_ctrl_pkg;

    // Flag load source select values for FLG_LD_SEL
    localparam logic FLG_SRC_ALU  = 1'b0;
    localparam logic FLG_SRC_SHAD = 1'b1;

    // Number of flops that condition INTR before edge detection
`ifdef RAT_INT_SYNC_EN
    localparam int unsigned INT_SYNC_DEPTH = 2;
`else
    localparam int unsigned INT_SYNC_DEPTH = 1;
`endif

endpackage

// File: rtl/int_edge_det.sv
// Conditions an asynchronous level input and emits a one-cycle pulse per
// low-to-high transition. Depth comes from INT_SYNC_DEPTH, which is
// controlled by the RAT_INT_SYNC_EN build option.
module int_edge_det
    import rat_ctrl_pkg::*;
(
    input  logic clk,
    input  logic RESET,
    input  logic async_in,
    output logic edge_out
);

    localparam int unsigned D = INT_SYNC_DEPTH;

    // smp_q[D-1] is the last conditioned sample; smp_q[D] is its delayed copy.
    // vld_q tracks which stages hold a real post-reset sample, so a level that
    // was already high through reset release is not mistaken for an edge.
    logic [D:0] smp_q, smp_d;
    logic [D:0] vld_q, vld_d;

    // Shift the sample and its validity marker down the chain
    always_comb begin
        smp_d = {smp_q[D-1:0], async_in};
        vld_d = {vld_q[D-1:0], 1'b1};
    end

    // Sample chain registers, cleared by reset
    always_ff @(posedge clk) begin
        if (RESET) begin
            smp_q <= '0;
            vld_q <= '0;
        end else begin
            smp_q <= smp_d;
            vld_q <= vld_d;
        end
    end

    assign edge_out = smp_q[D-1] & ~smp_q[D] & vld_q[D];

endmodule

// File: rtl/flags_int_unit.sv
// Carry/zero flags with a shadow copy, interrupt enable, and a latched
// interrupt request. INTR passes through int_edge_det; RAT_INT_SYNC_EN
// adds a second synchronizer flop (one extra cycle of INTR latency).
module flags_int_unit
    import rat_ctrl_pkg::*;
(
    input  logic clk,
    input  logic RESET,
    input  logic ALU_C,
    input  logic ALU_Z,
    input  logic C_CLEAR,
    input  logic C_SET,
    input  logic C_LD,
    input  logic Z_LD,
    input  logic FLG_LD_SEL,
    input  logic FLG_SHAD_LD,
    input  logic I_SET,
    input  logic I_CLR,
    input  logic INTR,
    output logic C_FLAG,
    output logic Z_FLAG,
    output logic I_FLAG,
    output logic INTV,
    output logic INT_PEND
);

    logic c_q, c_d;
    logic z_q, z_d;
    logic shad_c_q, shad_c_d;
    logic shad_z_q, shad_z_d;
    logic i_q, i_d;
    logic pend_q, pend_d;
    logic intr_edge;
    logic use_shad;

    int_edge_det u_int_edge_det (
        .clk      (clk),
        .RESET    (RESET),
        .async_in (INTR),
        .edge_out (intr_edge)
    );

    assign use_shad = (FLG_LD_SEL == FLG_SRC_SHAD);

    // Next-state for flags, shadow, interrupt enable and pending request
    always_comb begin
        c_d      = c_q;
        z_d      = z_q;
        shad_c_d = shad_c_q;
        shad_z_d = shad_z_q;
        i_d      = i_q;
        pend_d   = pend_q;

        if (C_CLEAR)
            c_d = 1'b0;
        else if (C_SET)
            c_d = 1'b1;
        else if (C_LD)
            c_d = use_shad ? shad_c_q : ALU_C;

        if (Z_LD)
            z_d = use_shad ? shad_z_q : ALU_Z;

        // Shadow captures the pre-edge live flags, not same-cycle loads
        if (FLG_SHAD_LD) begin
            shad_c_d = c_q;
            shad_z_d = z_q;
        end

        if (I_CLR)
            i_d = 1'b0;
        else if (I_SET)
            i_d = 1'b1;

        // A fresh edge beats the acknowledge so a request is never lost
        if (intr_edge)
            pend_d = 1'b1;
        else if (FLG_SHAD_LD)
            pend_d = 1'b0;
    end

    // State registers; reset overrides every strobe
    always_ff @(posedge clk) begin
        if (RESET) begin
            c_q      <= 1'b0;
            z_q      <= 1'b0;
            shad_c_q <= 1'b0;
            shad_z_q <= 1'b0;
            i_q      <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            c_q      <= c_d;
            z_q      <= z_d;
            shad_c_q <= shad_c_d;
            shad_z_q <= shad_z_d;
            i_q      <= i_d;
            pend_q   <= pend_d;
        end
    end

    assign C_FLAG   = c_q;
    assign Z_FLAG   = z_q;
    assign I_FLAG   = i_q;
    assign INT_PEND = pend_q;
    assign INTV     = pend_q & i_q;

endmodule

// File: tb/tb_flags_int_unit.sv
// Directed scoreboard bench for flags_int_unit. Expected output words
// {C,Z,I,INTV,PEND} are queued as each cycle is driven and compared after
// the clock edge. INTR latency follows the RAT_INT_SYNC_EN build option.
module tb_flags_int_unit;

    localparam int LAT =
`ifdef RAT_INT_SYNC_EN
        3;
`else
        2;
`endif

    logic clk = 1'b0;
    logic RESET = 1'b0;
    logic ALU_C = 1'b0, ALU_Z = 1'b0;
    logic C_CLEAR = 1'b0, C_SET = 1'b0, C_LD = 1'b0, Z_LD = 1'b0;
    logic FLG_LD_SEL = 1'b0, FLG_SHAD_LD = 1'b0;
    logic I_SET = 1'b0, I_CLR = 1'b0;
    logic INTR = 1'b0;
    logic C_FLAG, Z_FLAG, I_FLAG, INTV, INT_PEND;

    typedef struct {
        string      tag;
        logic [4:0] exp;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    int n_vec = 0;
    int n_err = 0;

    flags_int_unit dut (
        .clk         (clk),
        .RESET       (RESET),
        .ALU_C       (ALU_C),
        .ALU_Z       (ALU_Z),
        .C_CLEAR     (C_CLEAR),
        .C_SET       (C_SET),
        .C_LD        (C_LD),
        .Z_LD        (Z_LD),
        .FLG_LD_SEL  (FLG_LD_SEL),
        .FLG_SHAD_LD (FLG_SHAD_LD),
        .I_SET       (I_SET),
        .I_CLR       (I_CLR),
        .INTR        (INTR),
        .C_FLAG      (C_FLAG),
        .Z_FLAG      (Z_FLAG),
        .I_FLAG      (I_FLAG),
        .INTV        (INTV),
        .INT_PEND    (INT_PEND)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got {C,Z,I,INTV,PEND}=%b, required %b", tag, got, exp);
        end
    endtask

    // One clock: queue expectation, advance past the edge, compare, drop strobes
    task automatic cyc(input string tag, input logic [4:0] exp);
        sb_entry_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check(e.tag, {C_FLAG, Z_FLAG, I_FLAG, INTV, INT_PEND}, e.exp);
        C_CLEAR = 1'b0; C_SET = 1'b0; C_LD = 1'b0; Z_LD = 1'b0;
        FLG_SHAD_LD = 1'b0; I_SET = 1'b0; I_CLR = 1'b0;
    endtask

    initial begin
        // Reset overrides same-cycle strobes
        RESET = 1'b1; C_SET = 1'b1; I_SET = 1'b1; Z_LD = 1'b1; ALU_Z = 1'b1;
        cyc("rst_override", 5'b00000);
        RESET = 1'b0; ALU_Z = 1'b0;
        cyc("idle", 5'b00000);

        // Carry load, clear-over-set priority, set
        ALU_C = 1'b1; C_LD = 1'b1;
        cyc("c_ld_alu", 5'b10000);
        C_CLEAR = 1'b1; C_SET = 1'b1;
        cyc("c_clr_pri", 5'b00000);
        C_SET = 1'b1;
        cyc("c_set", 5'b10000);

        // Shadow capture with same-cycle live loads, then restore from shadow
        FLG_SHAD_LD = 1'b1; ALU_C = 1'b0; ALU_Z = 1'b1; C_LD = 1'b1; Z_LD = 1'b1;
        cyc("shad_cap", 5'b01000);
        FLG_LD_SEL = 1'b1; C_LD = 1'b1; Z_LD = 1'b1;
        cyc("shad_restore", 5'b10000);
        FLG_LD_SEL = 1'b0; ALU_Z = 1'b0;
        cyc("hold", 5'b10000);

        // Enabled interrupt: exact latency, acknowledge, held-high no re-pend
        I_SET = 1'b1;
        cyc("i_set", 5'b10100);
        INTR = 1'b1;
        for (int k = 1; k < LAT; k++) cyc("intr_wait", 5'b10100);
        cyc("intv_on", 5'b10111);
        FLG_SHAD_LD = 1'b1;
        cyc("ack", 5'b10100);
        for (int k = 0; k < 4; k++) cyc("held_high", 5'b10100);

        // Edge pulse coinciding with acknowledge keeps the request pending
        INTR = 1'b0;
        for (int k = 0; k <= LAT; k++) cyc("intr_low", 5'b10100);
        INTR = 1'b1;
        for (int k = 1; k < LAT; k++) cyc("intr_wait2", 5'b10100);
        FLG_SHAD_LD = 1'b1;
        cyc("edge_vs_ack", 5'b10111);
        FLG_SHAD_LD = 1'b1;
        cyc("ack2", 5'b10100);
        INTR = 1'b0;
        for (int k = 0; k <= LAT; k++) cyc("flush", 5'b10100);

        // Disabled interrupt: pending visible, INTV gated, then enable
        I_CLR = 1'b1;
        cyc("i_clr", 5'b10000);
        INTR = 1'b1;
        cyc("pulse_hi", 5'b10000);
        INTR = 1'b0;
        for (int k = 2; k < LAT; k++) cyc("pulse_wait", 5'b10000);
        cyc("pend_masked", 5'b10001);
        cyc("pend_hold", 5'b10001);
        I_SET = 1'b1;
        cyc("iset_intv", 5'b10111);
        I_SET = 1'b1; I_CLR = 1'b1;
        cyc("iclr_wins", 5'b10001);

        // Extra edge while pending is absorbed: one acknowledge clears it
        INTR = 1'b1;
        for (int k = 0; k <= LAT; k++) cyc("absorb_hi", 5'b10001);
        INTR = 1'b0;
        for (int k = 0; k <= LAT; k++) cyc("absorb_lo", 5'b10001);
        FLG_SHAD_LD = 1'b1;
        cyc("absorb_ack", 5'b10000);
        cyc("absorb_idle", 5'b10000);

        // Reset while pending with INTR high: discarded, no re-pend until toggle
        I_SET = 1'b1;
        cyc("i_set2", 5'b10100);
        INTR = 1'b1;
        for (int k = 1; k < LAT; k++) cyc("intr_wait3", 5'b10100);
        cyc("intv_on2", 5'b10111);
        RESET = 1'b1; C_SET = 1'b1; I_SET = 1'b1;
        cyc("rst_pend", 5'b00000);
        RESET = 1'b0;
        cyc("post_rst", 5'b00000);
        I_SET = 1'b1;
        cyc("post_rst_iset", 5'b00100);
        for (int k = 0; k < LAT + 2; k++) cyc("post_rst_held", 5'b00100);
        INTR = 1'b0;
        for (int k = 0; k <= LAT; k++) cyc("post_rst_low", 5'b00100);
        INTR = 1'b1;
        for (int k = 1; k < LAT; k++) cyc("repend_wait", 5'b00100);
        cyc("repend", 5'b00111);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
